// File: rtl/ccc_block_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ccc_block_scheduler
// Purpose  : Time-multiplexes a single ccc_encoder_4x4 across a frame. Raster
//            pixels are buffered one 4-row strip at a time. Each 4x4 block of
//            the strip is handed to the encoder, and the 64-bit CCC results
//            are emitted in raster block order.
// Ports    : clk, rst (async, active-low)
//            start / busy / frame_done        frame control
//            s_valid / s_ready / s_data[23:0] pixel stream in, {R,G,B}
//            enc_rgb[383:0] / enc_start       block out to encoder
//            enc_done / enc_ccc[63:0]         encoder result in
//            m_valid / m_ready / m_data[63:0] / m_last   CCC stream out
// Revision : 1.0 - initial release
// ============================================================================
module ccc_block_scheduler #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         busy,
  output logic         frame_done,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [23:0]  s_data,
  output logic [383:0] enc_rgb,
  output logic         enc_start,
  input  logic         enc_done,
  input  logic [63:0]  enc_ccc,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [63:0]  m_data,
  output logic         m_last
);

  localparam int c_BLK_X = WIDTH / 4;
  localparam int c_BLK_Y = HEIGHT / 4;
  localparam int COL_W   = $clog2(WIDTH);
  localparam int BX_W    = (c_BLK_X > 1) ? $clog2(c_BLK_X) : 1;
  localparam int BY_W    = (c_BLK_Y > 1) ? $clog2(c_BLK_Y) : 1;

  localparam logic [COL_W-1:0] c_COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [BX_W-1:0]  c_BX_LAST  = BX_W'(c_BLK_X - 1);
  localparam logic [BY_W-1:0]  c_BY_LAST  = BY_W'(c_BLK_Y - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_EMIT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [COL_W-1:0]   r_col;
  logic [1:0]         r_row;
  logic [BX_W-1:0]    r_bx;
  logic [BY_W-1:0]    r_by;
  logic [63:0]        r_m_data;
  logic               r_m_last;
  logic [23:0]        r_strip [4][WIDTH];

  logic               w_fill_hs;
  logic               w_strip_last;
  logic               w_emit_hs;
  logic               w_bx_last;
  logic               w_by_last;
  logic [COL_W-1:0]   w_base;
  logic [383:0]       w_blk;

  assign w_fill_hs    = (r_state == S_FILL) && s_valid;
  assign w_strip_last = w_fill_hs && (r_row == 2'd3) && (r_col == c_COL_LAST);
  assign w_emit_hs    = (r_state == S_EMIT) && m_ready;
  assign w_bx_last    = (r_bx == c_BX_LAST);
  assign w_by_last    = (r_by == c_BY_LAST);

  // Left-most column of the current block within the strip.
  assign w_base = COL_W'({r_bx, 2'b00});

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_FILL;
      S_FILL:  if (w_strip_last) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (enc_done) w_next = S_EMIT;
      S_EMIT: begin
        if (m_ready) begin
          if (!w_bx_last)      w_next = S_ISSUE;
          else if (!w_by_last) w_next = S_FILL;
          else                 w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ------------------------------------------------ counters and result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col    <= '0;
      r_row    <= '0;
      r_bx     <= '0;
      r_by     <= '0;
      r_m_data <= '0;
      r_m_last <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && start) begin
        r_col <= '0;
        r_row <= '0;
        r_bx  <= '0;
        r_by  <= '0;
      end
      if (w_fill_hs) begin
        if (r_col == c_COL_LAST) begin
          r_col <= '0;
          r_row <= r_row + 2'd1;
        end else begin
          r_col <= r_col + COL_W'(1);
        end
        if (w_strip_last) r_bx <= '0;
      end
      if ((r_state == S_WAIT) && enc_done) begin
        r_m_data <= enc_ccc;
        r_m_last <= w_bx_last && w_by_last;
      end
      if (w_emit_hs) begin
        if (!w_bx_last) begin
          r_bx <= r_bx + BX_W'(1);
        end else begin
          r_bx <= '0;
          // Wraps to 0 after the last strip so the next frame starts clean.
          r_by <= w_by_last ? '0 : r_by + BY_W'(1);
        end
      end
    end
  end

  // Strip buffer: contents are don't-care after reset, so no reset term.
  always_ff @(posedge clk) begin
    if (w_fill_hs) r_strip[r_row][r_col] <= s_data;
  end

  // ------------------------------------------------- block extraction
  for (genvar gr = 0; gr < 4; gr++) begin : g_row
    for (genvar gp = 0; gp < 4; gp++) begin : g_px
      assign w_blk[(gr*4+gp)*24 +: 24] = r_strip[gr][w_base + COL_W'(gp)];
    end
  end

  // Presented only while the encoder owns the block; zero otherwise so the
  // bus is quiet in idle and immediately after reset.
  assign enc_rgb = ((r_state == S_ISSUE) || (r_state == S_WAIT)) ? w_blk : '0;

  // --------------------------------------------------------- outputs
  assign busy       = (r_state != S_IDLE);
  assign frame_done = (r_state == S_DONE);
  assign s_ready    = (r_state == S_FILL);
  assign enc_start  = (r_state == S_ISSUE);
  assign m_valid    = (r_state == S_EMIT);
  assign m_data     = r_m_data;
  assign m_last     = r_m_last && (r_state == S_EMIT);

endmodule
`default_nettype wire

// File: tb/tb_ccc_block_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_ccc_block_scheduler
// Purpose  : Self-checking bench for ccc_block_scheduler on an 8x8 frame.
//            A frame-level reference (pixel formula, block order, hash) gives
//            the expected encoder blocks and CCC outputs; an ideal encoder
//            answers 2 cycles after each start.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ccc_block_scheduler;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int NB = (W / 4) * (H / 4);

  logic         clk;
  logic         rst;
  logic         start;
  logic         busy;
  logic         frame_done;
  logic         s_valid;
  logic         s_ready;
  logic [23:0]  s_data;
  logic [383:0] enc_rgb;
  logic         enc_start;
  logic         enc_done;
  logic [63:0]  enc_ccc;
  logic         m_valid;
  logic         m_ready;
  logic [63:0]  m_data;
  logic         m_last;

  logic r_go;
  logic r_stray;
  assign start = r_go | r_stray;

  ccc_block_scheduler #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .frame_done(frame_done),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .enc_rgb(enc_rgb), .enc_start(enc_start), .enc_done(enc_done), .enc_ccc(enc_ccc),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int mready_mode;  // 0 always ready, 1 ready 1-of-3, 2 random
    int gaps;         // random s_valid gaps
    int hold;         // encoder done-high cycles
    int off;          // pixel value offset
    int stray;        // pulse start during FILL and EMIT
    int exp_blocks;
    int exp_fd;
  } vec_t;

  vec_t tbl [6];

  int n_chk, n_fail;
  int cfg_mready, cfg_gaps, cfg_hold, cfg_off, cfg_stray;
  int src_n, m_emitted, starts, fd_count, cyc;
  int enc_delay, enc_left;
  bit enc_first, mon_en, prev_stall, exp_fd, stray_fill, stray_emit;
  logic [383:0] enc_lat;
  logic [63:0]  prev_data;
  logic         prev_last;
  logic         sv_sv, sv_sr, sv_mv, sv_mr, sv_ml, sv_fd, sv_st;
  logic [383:0] sv_rgb;

  // ---------------------------------------------------- reference model
  function automatic logic [23:0] pix(int n, int off);
    int v;
    v = n + off;
    return {8'(v), 8'(v + 1), 8'(v + 2)};
  endfunction

  function automatic logic [383:0] ref_block(int k, int off);
    logic [383:0] b;
    int bx, by;
    b  = '0;
    bx = k % (W / 4);
    by = k / (W / 4);
    for (int r = 0; r < 4; r++)
      for (int p = 0; p < 4; p++)
        b[(r*4+p)*24 +: 24] = pix((by*4 + r)*W + bx*4 + p, off);
    return b;
  endfunction

  function automatic logic [63:0] hash(logic [383:0] rgb);
    logic [63:0] h;
    h = 64'h9E37_79B9_7F4A_7C15;
    for (int i = 0; i < 6; i++) h = {h[50:0], h[63:51]} ^ rgb[i*64 +: 64];
    return h;
  endfunction

  task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // --------------------------- monitor, pixel source, sink, encoder model
  initial begin : p_bg
    forever begin
      @(negedge clk);
      sv_sv = s_valid; sv_sr = s_ready; sv_mv = m_valid; sv_mr = m_ready;
      sv_ml = m_last;  sv_fd = frame_done; sv_st = enc_start; sv_rgb = enc_rgb;
      if (mon_en) begin
        if (prev_stall)
          chk("stall_hold", 384'({m_valid, m_last, m_data}), 384'({1'b1, prev_last, prev_data}));
        if (s_ready)
          chk("fill_after_strip_emitted", 384'(m_emitted), 384'((src_n / (4*W)) * (W/4)));
        if (enc_start || m_valid)
          chk("s_ready_low", 384'(s_ready), 384'(1'b0));
        if (exp_fd || frame_done)
          chk("frame_done", 384'(frame_done), 384'(exp_fd));
        if (enc_start) begin
          chk("enc_rgb", enc_rgb, (starts < NB) ? ref_block(starts, cfg_off) : '0);
          if (cfg_off == 0 && starts == 1)
            chk("blk10_px0", 384'(enc_rgb[23:0]), 384'(pix(4, 0)));
        end
        if (enc_done && enc_first)
          chk("enc_rgb_held", enc_rgb, enc_lat);
        if (m_valid && m_ready) begin
          chk("block_in_range", 384'(m_emitted < NB), 384'(1'b1));
          if (m_emitted < NB) begin
            chk("m_data", 384'(m_data), 384'(hash(ref_block(m_emitted, cfg_off))));
            chk("m_last", 384'(m_last), 384'(m_emitted == NB - 1));
          end
        end
      end
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (sv_sv && sv_sr) src_n++;
        if (sv_mv && sv_mr) m_emitted++;
        exp_fd     = sv_mv && sv_mr && sv_ml;
        if (sv_fd) fd_count++;
        prev_stall = sv_mv && !sv_mr;
        prev_data  = m_data;
        prev_last  = sv_ml;
        // ideal encoder: done two cycles after start, for cfg_hold cycles;
        // a new start cancels any done still being held
        enc_first = 1'b0;
        if (enc_left > 0) enc_left--;
        if (enc_delay > 0) begin
          enc_delay--;
          if (enc_delay == 0) begin
            enc_left  = cfg_hold;
            enc_first = 1'b1;
          end
        end
        if (sv_st) begin
          starts++;
          enc_lat   = sv_rgb;
          enc_delay = 1;
          enc_left  = 0;
        end
        enc_done = (enc_left > 0);
        enc_ccc  = enc_done ? hash(enc_lat) : 64'd0;
        cyc++;
        case (cfg_mready)
          0:       m_ready = 1'b1;
          1:       m_ready = (cyc % 3 == 0);
          default: m_ready = 1'($urandom % 2);
        endcase
        s_valid = (src_n < W*H) && (cfg_gaps == 0 || ($urandom % 2) == 1);
        s_data  = (src_n < W*H) ? pix(src_n, cfg_off) : 24'd0;
        r_stray = 1'b0;
        if (cfg_stray != 0) begin
          if (!stray_fill && sv_sr && src_n >= 3) begin
            r_stray = 1'b1; stray_fill = 1'b1;
          end else if (!stray_emit && sv_mv && !sv_mr) begin
            r_stray = 1'b1; stray_emit = 1'b1;
          end
        end
      end else begin
        s_valid = 1'b0; s_data = '0; enc_done = 1'b0; enc_ccc = '0;
        m_ready = 1'b0; r_stray = 1'b0; prev_stall = 1'b0; exp_fd = 1'b0;
        enc_first = 1'b0;
      end
    end
  end

  task automatic clear_track(input vec_t v);
    cfg_mready = v.mready_mode; cfg_gaps = v.gaps; cfg_hold = v.hold;
    cfg_off = v.off; cfg_stray = v.stray;
    src_n = 0; m_emitted = 0; starts = 0; fd_count = 0; cyc = 0;
    enc_delay = 0; enc_left = 0; stray_fill = 1'b0; stray_emit = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #2;
    mon_en = 1'b1;
    r_go   = 1'b1;
    @(posedge clk); #2;
    r_go = 1'b0;
    chk("busy_after_start", 384'(busy), 384'(1'b1));
  endtask

  task automatic run_frame(input vec_t v, input int idx);
    int t;
    clear_track(v);
    pulse_start();
    t = 0;
    while (fd_count == 0 && t < 4000) begin
      @(posedge clk); #2;
      t++;
    end
    if (fd_count == 0) $display("FAIL frame_timeout: vector %0d got no frame_done", idx);
    chk("frame_completed", 384'(fd_count > 0), 384'(1'b1));
    repeat (6) @(posedge clk);
    #2;
    mon_en = 1'b0;
    chk("blocks_emitted", 384'(m_emitted), 384'(v.exp_blocks));
    chk("enc_starts", 384'(starts), 384'(v.exp_blocks));
    chk("frame_done_count", 384'(fd_count), 384'(v.exp_fd));
    chk("pixels_consumed", 384'(src_n), 384'(W*H));
    chk("busy_idle", 384'(busy), 384'(1'b0));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 384'(busy), '0);
    chk({tag, "_frame_done"}, 384'(frame_done), '0);
    chk({tag, "_s_ready"}, 384'(s_ready), '0);
    chk({tag, "_enc_start"}, 384'(enc_start), '0);
    chk({tag, "_m_valid"}, 384'(m_valid), '0);
    chk({tag, "_m_last"}, 384'(m_last), '0);
    chk({tag, "_m_data"}, 384'(m_data), '0);
    chk({tag, "_enc_rgb"}, enc_rgb, '0);
  endtask

  // --------------------------------------------------------------- main
  initial begin : p_main
    int t;
    n_chk = 0; n_fail = 0; mon_en = 1'b0;
    rst = 1'b0; r_go = 1'b0;
    tbl[0] = '{0, 0, 1,  0, 0, NB, 1};
    tbl[1] = '{1, 0, 1,  0, 0, NB, 1};
    tbl[2] = '{0, 1, 1,  0, 0, NB, 1};
    tbl[3] = '{1, 0, 1, 17, 1, NB, 1};
    tbl[4] = '{2, 1, 5, 99, 0, NB, 1};
    tbl[5] = '{0, 0, 5,  3, 0, NB, 1};

    repeat (2) @(posedge clk);
    #2;
    chk_all_zero("reset");
    // start while reset is held: reset wins
    r_go = 1'b1;
    @(posedge clk); #2;
    chk("start_in_reset", 384'(busy), 384'(1'b0));
    r_go = 1'b0;
    @(negedge clk) rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("idle_without_start", 384'(busy), 384'(1'b0));

    // back-to-back frames: each one after the first starts from IDLE
    for (int i = 0; i < 6; i++) run_frame(tbl[i], i);

    // reset asserted while block (1,0) waits on the encoder
    clear_track(tbl[0]);
    pulse_start();
    t = 0;
    while (starts < 2 && t < 2000) begin
      @(posedge clk); #2;
      t++;
    end
    chk("reached_block10", 384'(starts), 384'(2));
    mon_en = 1'b0;
    #1 rst = 1'b0;
    #1 chk_all_zero("mid_reset");
    @(negedge clk) rst = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    chk("no_auto_restart", 384'(busy), 384'(1'b0));
    run_frame(tbl[0], 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
